// File: rtl/tdc_encoder_pipe.sv
// tdc_encoder_pipe: pipelined thermometer-code TOA/TOT encoder feeding a first-word-fall-through FIFO.
// Define TDC_ENC_MON_EN to add gated monitor taps (mon_raw, mon_cnt_a, mon_cnt_b, enable_mon) on the capture registers.
module tdc_encoder_pipe #(
  parameter int RAW_W      = 63,
  parameter int FINE_W     = 7,
  parameter int CNT_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          RawdataWrtClk,
  input  logic                          ResetFlag,
  input  logic                          hit_in,
  input  logic [RAW_W-1:0]              raw_data,
  input  logic [CNT_W-1:0]              counter_a,
  input  logic [CNT_W-1:0]              counter_b,
  input  logic [2:0]                    level,
  input  logic [FINE_W-1:0]             offset,
  input  logic                          sel_raw_code,
  input  logic                          out_ready,
  input  logic                          clear_drop,
  output logic                          out_valid,
  output logic [CNT_W+FINE_W-1:0]       out_code,
  output logic                          out_error,
  output logic [1:0]                    out_bubble,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
`ifdef TDC_ENC_MON_EN
  ,
  input  logic                          enable_mon,
  output logic [RAW_W-1:0]              mon_raw,
  output logic [CNT_W-1:0]              mon_cnt_a,
  output logic [CNT_W-1:0]              mon_cnt_b
`endif
);

  localparam int CODE_W   = CNT_W + FINE_W;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int HALF_RAW = RAW_W / 2;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              error;
    logic [1:0]        bubble;
  } fifoEntryT;

  // Stage 0: capture registers
  logic              s0Valid;
  logic [RAW_W-1:0]  s0Raw;
  logic [CNT_W-1:0]  s0CntA;
  logic [CNT_W-1:0]  s0CntB;
  logic [2:0]        s0Level;
  logic [FINE_W-1:0] s0Offset;
  logic              s0SelRaw;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of its inputs, independent of block order.
  always_ff @(posedge RawdataWrtClk or negedge ResetFlag) begin
    if (!ResetFlag) begin
      s0Valid  <= 1'b0;
      s0Raw    <= '0;
      s0CntA   <= '0;
      s0CntB   <= '0;
      s0Level  <= '0;
      s0Offset <= '0;
      s0SelRaw <= 1'b0;
    end else begin
      s0Valid <= hit_in;
      if (hit_in) begin
        s0Raw    <= raw_data;
        s0CntA   <= counter_a;
        s0CntB   <= counter_b;
        s0Level  <= level;
        s0Offset <= offset;
        s0SelRaw <= sel_raw_code;
      end
    end
  end

  // Stage 1: encode
  logic [FINE_W-1:0] fineCount;
  logic [FINE_W-1:0] bubbleCount;
  logic [CNT_W-1:0]  coarseSel;
  logic [CODE_W-1:0] rawCode;
  logic [CODE_W-1:0] corrCode;
  fifoEntryT         encEntry;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    fineCount   = '0;
    bubbleCount = '0;
    for (int i = 0; i < RAW_W; i++)
      fineCount = fineCount + FINE_W'(s0Raw[i]);
    // A bubble is a 0 sitting below a 1 in what should be a clean thermometer run.
    for (int i = 0; i < RAW_W - 1; i++)
      bubbleCount = bubbleCount + FINE_W'(!s0Raw[i] && s0Raw[i+1]);
  end

  always_comb begin
    coarseSel = (fineCount < FINE_W'(HALF_RAW)) ? s0CntA : s0CntB;
    rawCode   = {coarseSel, fineCount};
    corrCode  = rawCode - CODE_W'(s0Offset);
    encEntry.code   = s0SelRaw ? rawCode : corrCode;
    encEntry.error  = bubbleCount > FINE_W'(s0Level);
    encEntry.bubble = (bubbleCount > FINE_W'(3)) ? 2'd3 : bubbleCount[1:0];
  end

  logic      s1Valid;
  fifoEntryT s1Entry;

  always_ff @(posedge RawdataWrtClk or negedge ResetFlag) begin
    if (!ResetFlag) begin
      s1Valid <= 1'b0;
      s1Entry <= '0;
    end else begin
      s1Valid <= s0Valid;
      if (s0Valid)
        s1Entry <= encEntry;
    end
  end

  // Stage 2: output FIFO, first-word fall-through
  fifoEntryT        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [LVL_W-1:0] fifoCount;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             popEn;
  logic             pushEn;
  logic             dropEn;

  assign fifoEmpty = (fifoCount == '0);
  assign fifoFull  = (fifoCount == LVL_W'(FIFO_DEPTH));
  assign popEn     = !fifoEmpty && out_ready;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign pushEn    = s1Valid && (!fifoFull || popEn);
  assign dropEn    = s1Valid && fifoFull && !popEn;

  // NOTE: the storage array has no reset; stale contents are never visible
  // because the outputs are masked while the FIFO is empty.
  always_ff @(posedge RawdataWrtClk) begin
    if (pushEn)
      fifoMem[wrPtr] <= s1Entry;
  end

  always_ff @(posedge RawdataWrtClk or negedge ResetFlag) begin
    if (!ResetFlag) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (pushEn)
        wrPtr <= wrPtr + 1'b1;
      if (popEn)
        rdPtr <= rdPtr + 1'b1;
      case ({pushEn, popEn})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  // Saturating drop counter; a clear in the same cycle as a drop wins.
  always_ff @(posedge RawdataWrtClk or negedge ResetFlag) begin
    if (!ResetFlag)
      drop_cnt <= '0;
    else if (clear_drop)
      drop_cnt <= '0;
    else if (dropEn && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end

  fifoEntryT headEntry;

  assign headEntry  = fifoEmpty ? '0 : fifoMem[rdPtr];
  assign out_valid  = !fifoEmpty;
  assign out_code   = headEntry.code;
  assign out_error  = headEntry.error;
  assign out_bubble = headEntry.bubble;
  assign fifo_level = fifoCount;

`ifdef TDC_ENC_MON_EN
  assign mon_raw   = enable_mon ? s0Raw  : '0;
  assign mon_cnt_a = enable_mon ? s0CntA : '0;
  assign mon_cnt_b = enable_mon ? s0CntB : '0;
`endif

endmodule

// File: tb/tb_tdc_encoder_pipe.sv
// Self-checking bench for tdc_encoder_pipe: directed vector table, FIFO corner sequences,
// and randomized traffic against a transaction-level queue model.
module tb_tdc_encoder_pipe;

  localparam int RAW_W  = 63;
  localparam int FINE_W = 7;
  localparam int CNT_W  = 3;
  localparam int CODE_W = CNT_W + FINE_W;
  localparam int DEPTH  = 4;

  logic              RawdataWrtClk = 1'b0;
  logic              ResetFlag;
  logic              hit_in;
  logic [RAW_W-1:0]  raw_data;
  logic [CNT_W-1:0]  counter_a;
  logic [CNT_W-1:0]  counter_b;
  logic [2:0]        level;
  logic [FINE_W-1:0] offset;
  logic              sel_raw_code;
  logic              out_ready;
  logic              clear_drop;
  logic              out_valid;
  logic [CODE_W-1:0] out_code;
  logic              out_error;
  logic [1:0]        out_bubble;
  logic [2:0]        fifo_level;
  logic [7:0]        drop_cnt;
`ifdef TDC_ENC_MON_EN
  logic              enable_mon;
  logic [RAW_W-1:0]  mon_raw;
  logic [CNT_W-1:0]  mon_cnt_a;
  logic [CNT_W-1:0]  mon_cnt_b;
`endif

  tdc_encoder_pipe #(
    .RAW_W(RAW_W), .FINE_W(FINE_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .RawdataWrtClk(RawdataWrtClk),
    .ResetFlag(ResetFlag),
    .hit_in(hit_in),
    .raw_data(raw_data),
    .counter_a(counter_a),
    .counter_b(counter_b),
    .level(level),
    .offset(offset),
    .sel_raw_code(sel_raw_code),
    .out_ready(out_ready),
    .clear_drop(clear_drop),
    .out_valid(out_valid),
    .out_code(out_code),
    .out_error(out_error),
    .out_bubble(out_bubble),
    .fifo_level(fifo_level),
    .drop_cnt(drop_cnt)
`ifdef TDC_ENC_MON_EN
    ,
    .enable_mon(enable_mon),
    .mon_raw(mon_raw),
    .mon_cnt_a(mon_cnt_a),
    .mon_cnt_b(mon_cnt_b)
`endif
  );

  always #5 RawdataWrtClk = ~RawdataWrtClk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [RAW_W-1:0]  raw;
    logic [CNT_W-1:0]  cntA;
    logic [CNT_W-1:0]  cntB;
    logic [2:0]        lvl;
    logic [FINE_W-1:0] off;
    logic              sel;
    int                expCode;
    int                expErr;
    int                expBub;
  } vecT;

  typedef struct {
    int code;
    int err;
    int bub;
  } resT;

  // Reference encoder straight from the arithmetic definition.
  function automatic resT refEncode(input logic [RAW_W-1:0] raw, input int a, input int b,
                                    input int lvl, input int off, input bit sel);
    resT r;
    int ones;
    int bub;
    int coarse;
    int rawCode;
    ones = $countones(raw);
    bub  = 0;
    for (int i = 0; i < RAW_W - 1; i++)
      if (raw[i] == 1'b0 && raw[i+1] == 1'b1) bub++;
    coarse  = (ones < RAW_W / 2) ? a : b;
    rawCode = coarse * (2 ** FINE_W) + ones;
    r.code  = sel ? rawCode : (rawCode - off + (2 ** CODE_W)) % (2 ** CODE_W);
    r.err   = (bub > lvl) ? 1 : 0;
    r.bub   = (bub > 3) ? 3 : bub;
    return r;
  endfunction

  task automatic driveIdle();
    hit_in       = 1'b0;
    raw_data     = '0;
    counter_a    = '0;
    counter_b    = '0;
    level        = '0;
    offset       = '0;
    sel_raw_code = 1'b0;
    clear_drop   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vecT vecs [8];
  resT mq [$];
  resT pipeE [2];
  bit  pipeV [2];
  int  modelDrop;

  initial begin
    vecs[0] = '{63'h00000000000FFFFF, 3'd5, 3'd6, 3'd0, 7'd0, 1'b0, 660, 0, 0};
    vecs[1] = '{63'h000000000000FFDF, 3'd5, 3'd6, 3'd0, 7'd0, 1'b0, 655, 1, 1};
    vecs[2] = '{63'h000000000000FFDF, 3'd5, 3'd6, 3'd1, 7'd0, 1'b0, 655, 0, 1};
    vecs[3] = '{63'h0,                3'd0, 3'd6, 3'd0, 7'd3, 1'b0, 1021, 0, 0};
    vecs[4] = '{63'h0,                3'd0, 3'd6, 3'd0, 7'd3, 1'b1, 0, 0, 0};
    vecs[5] = '{63'h000000FFFFFFFFFF, 3'd2, 3'd3, 3'd0, 7'd0, 1'b0, 424, 0, 0};
    vecs[6] = '{63'h7FFFFFFFFFFFFFFF, 3'd5, 3'd6, 3'd0, 7'd0, 1'b0, 831, 0, 0};
    vecs[7] = '{63'h5555555555555555, 3'd1, 3'd2, 3'd7, 7'd0, 1'b0, 288, 1, 3};

    driveIdle();
    out_ready = 1'b1;
`ifdef TDC_ENC_MON_EN
    enable_mon = 1'b1;
`endif
    ResetFlag = 1'b0;
    repeat (3) @(negedge RawdataWrtClk);
    check("reset_valid", out_valid, 0);
    check("reset_level", fifo_level, 0);
    check("reset_drop", drop_cnt, 0);
    check("reset_code", out_code, 0);
    ResetFlag = 1'b1;
    @(negedge RawdataWrtClk);

    // Directed vectors: one isolated hit each, checking latency and the encoded head.
    for (int v = 0; v < 8; v++) begin
      hit_in       = 1'b1;
      raw_data     = vecs[v].raw;
      counter_a    = vecs[v].cntA;
      counter_b    = vecs[v].cntB;
      level        = vecs[v].lvl;
      offset       = vecs[v].off;
      sel_raw_code = vecs[v].sel;
      @(negedge RawdataWrtClk);
      hit_in = 1'b0;
      check($sformatf("vec%0d_valid_n", v), out_valid, 0);
      @(negedge RawdataWrtClk);
      check($sformatf("vec%0d_valid_n1", v), out_valid, 0);
      @(negedge RawdataWrtClk);
      check($sformatf("vec%0d_valid_n2", v), out_valid, 1);
      check($sformatf("vec%0d_code", v), out_code, vecs[v].expCode);
      check($sformatf("vec%0d_error", v), out_error, vecs[v].expErr);
      check($sformatf("vec%0d_bubble", v), out_bubble, vecs[v].expBub);
      check($sformatf("vec%0d_level", v), fifo_level, 1);
    end
    @(negedge RawdataWrtClk);
    check("drain_empty", out_valid, 0);

    // Six back-to-back hits into a stalled FIFO: four kept, two dropped.
    driveIdle();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hit_in    = 1'b1;
      raw_data  = 63'hF;
      counter_a = CNT_W'(i);
      counter_b = 3'd7;
      @(negedge RawdataWrtClk);
    end
    hit_in = 1'b0;
    repeat (3) @(negedge RawdataWrtClk);
    check("full_level", fifo_level, 4);
    check("full_drop", drop_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pop%0d_valid", i), out_valid, 1);
      check($sformatf("pop%0d_code", i), out_code, i * 128 + 4);
      out_ready = 1'b1;
      @(negedge RawdataWrtClk);
    end
    check("popped_valid", out_valid, 0);
    check("popped_level", fifo_level, 0);
    check("drop_held", drop_cnt, 2);
    clear_drop = 1'b1;
    @(negedge RawdataWrtClk);
    clear_drop = 1'b0;
    check("drop_cleared", drop_cnt, 0);

    // Reset with hits in flight discards everything.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hit_in    = 1'b1;
      raw_data  = 63'hFF;
      counter_a = 3'd1;
      @(negedge RawdataWrtClk);
    end
    hit_in = 1'b0;
    check("inflight_level", fifo_level, 1);
    #1 ResetFlag = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_level", fifo_level, 0);
    repeat (2) @(negedge RawdataWrtClk);
    ResetFlag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge RawdataWrtClk);
      check($sformatf("rst_post%0d_valid", i), out_valid, 0);
      check($sformatf("rst_post%0d_level", i), fifo_level, 0);
    end

    // Randomized traffic against a queue model; pipeline is idle and counters are zero here.
    modelDrop = 0;
    pipeV[0]  = 1'b0;
    pipeV[1]  = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit pop;
      bit pushV;
      resT pushE;
      int  n;
      check("rnd_valid", out_valid, (mq.size() > 0) ? 1 : 0);
      check("rnd_level", fifo_level, mq.size());
      check("rnd_drop", drop_cnt, modelDrop);
      if (mq.size() > 0) begin
        check("rnd_code", out_code, mq[0].code);
        check("rnd_error", out_error, mq[0].err);
        check("rnd_bubble", out_bubble, mq[0].bub);
      end

      hit_in = ($urandom_range(0, 3) != 0);
      n = $urandom_range(0, RAW_W);
      raw_data = (RAW_W'(1) << n) - RAW_W'(1);
      for (int k = $urandom_range(0, 3); k > 0; k--)
        raw_data = raw_data ^ (RAW_W'(1) << $urandom_range(0, RAW_W - 1));
      counter_a    = CNT_W'($urandom_range(0, 7));
      counter_b    = CNT_W'($urandom_range(0, 7));
      level        = 3'($urandom_range(0, 7));
      offset       = FINE_W'($urandom_range(0, 127));
      sel_raw_code = ($urandom_range(0, 3) == 0);
      out_ready    = ($urandom_range(0, 2) == 0);
      clear_drop   = ($urandom_range(0, 40) == 0);

      pop   = (mq.size() > 0) && out_ready;
      pushV = pipeV[1];
      pushE = pipeE[1];
      pipeV[1] = pipeV[0];
      pipeE[1] = pipeE[0];
      pipeV[0] = hit_in;
      pipeE[0] = refEncode(raw_data, counter_a, counter_b, level, offset, sel_raw_code);
      if (pop)
        void'(mq.pop_front());
      if (pushV) begin
        if (mq.size() < DEPTH)
          mq.push_back(pushE);
        else if (!clear_drop && modelDrop < 255)
          modelDrop++;
      end
      if (clear_drop)
        modelDrop = 0;
      @(negedge RawdataWrtClk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
